triumph_if_stage: RTL and testbench

//   Instruction-fetch stage. Generates the fetch PC, requests words from the instruction

---
 rtl/triumph_if_stage.sv | 185 ++++++++++++++++++
 tb/tb_triumph_if_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/triumph_if_stage.sv
// triumph_if_stage
//   Instruction-fetch stage. Generates the fetch PC, requests words from the
//   instruction cache over a req/gnt/rvalid interface and buffers returned
//   words in a small FIFO that feeds triumph_id_stage.
//
//   Ports
//     clk_i           clock, all state on the rising edge
//     rstn_i          asynchronous reset, active-high (1 = reset)
//     stall_i         ID cannot accept an instruction this cycle
//     redirect_i      branch/jump from EX, one-cycle pulse
//     redirect_pc_i   new fetch PC (bits [1:0] forced to 0)
//     icache_req_o    fetch request
//     icache_addr_o   word-aligned fetch address
//     icache_gnt_i    request accepted this cycle
//     icache_rvalid_i read data valid (in order, >= 1 cycle after gnt)
//     icache_rdata_i  instruction word
//     instr_valid_o   head of the instruction buffer is valid
//     instr_data_o    instruction at the buffer head
//     instr_pc_o      PC of the instruction at the buffer head
module triumph_if_stage #(
   parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        icache_req_o,
   output logic [31:0] icache_addr_o,
   input  logic        icache_gnt_i,
   input  logic        icache_rvalid_i,
   input  logic [31:0] icache_rdata_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_data_o,
   output logic [31:0] instr_pc_o
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT} state_t;

   state_t          state;
   state_t          state_nxt;

   logic [31:0]     fetch_pc;
   logic [31:0]     pend_pc;
   logic            pend;
   logic [31:0]     target;

   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   discard;
   logic [CW-1:0]   count;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   tag_wr;
   logic [PW-1:0]   tag_rd;

   logic [31:0]     fifo_data [FIFO_DEPTH];
   logic [31:0]     fifo_pc   [FIFO_DEPTH];
   logic [31:0]     tag_mem   [FIFO_DEPTH];

   logic            grant;
   logic            rv;
   logic            drop;
   logic            push;
   logic            pop;
   logic [CW-1:0]   out_nxt;
   logic [CW-1:0]   cnt_nxt;
   logic [CW-1:0]   disc_nxt;
   logic            credit_nxt;

   // Bookkeeping shared by the FSM and the datapath. Credit is judged on
   // next-cycle occupancy so a buffer slot is reserved for every request
   // before it is issued.
   always_comb begin
      target     = redirect_pc_i & 32'hFFFF_FFFC;
      grant      = (state == S_REQ) && icache_gnt_i;
      // A late response with nothing outstanding (e.g. across reset) is ignored.
      rv         = icache_rvalid_i && (outstanding != '0);
      drop       = rv && ((discard != '0) || redirect_i);
      push       = rv && !drop;
      pop        = (count != '0) && !stall_i;
      out_nxt    = outstanding + CW'(grant) - CW'(rv);
      if (redirect_i) cnt_nxt = '0;
      else            cnt_nxt = count + CW'(push) - CW'(pop);
      credit_nxt = ({1'b0, out_nxt} + {1'b0, cnt_nxt}) < DEPTH_W;
      // Everything still in flight after a redirect belongs to the old path;
      // a request held across a redirect joins the discard count once granted.
      if (redirect_i) disc_nxt = out_nxt;
      else            disc_nxt = discard - CW'(rv && (discard != '0))
                                         + CW'(grant && pend);
   end

   // FSM: state register
   always_ff @(posedge clk_i or posedge rstn_i) begin
      if (rstn_i) state <= S_BOOT;
      else        state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_BOOT:  state_nxt = S_REQ;
         S_REQ:   if (icache_gnt_i) state_nxt = credit_nxt ? S_REQ : S_WAIT;
         S_WAIT:  state_nxt = credit_nxt ? S_REQ : S_WAIT;
         default: state_nxt = S_BOOT;
      endcase
   end

   // FSM: outputs. The address only moves on a grant, so req/addr stay stable
   // while a request waits.
   always_comb begin
      icache_req_o  = (state == S_REQ);
      icache_addr_o = fetch_pc;
   end

   // Fetch PC, redirect handling and counters
   always_ff @(posedge clk_i or posedge rstn_i) begin
      if (rstn_i) begin
         fetch_pc    <= BOOT_ADDR;
         pend_pc     <= '0;
         pend        <= 1'b0;
         outstanding <= '0;
         discard     <= '0;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         tag_wr      <= '0;
         tag_rd      <= '0;
      end else begin
         outstanding <= out_nxt;
         discard     <= disc_nxt;
         count       <= cnt_nxt;

         if (redirect_i) begin
            // A request that is up but not granted must keep its address,
            // so the new target is parked until that grant arrives.
            if ((state == S_REQ) && !icache_gnt_i) begin
               pend    <= 1'b1;
               pend_pc <= target;
            end else begin
               pend     <= 1'b0;
               fetch_pc <= target;
            end
         end else if (grant) begin
            if (pend) begin
               pend     <= 1'b0;
               fetch_pc <= pend_pc;
            end else begin
               fetch_pc <= fetch_pc + 32'd4;
            end
         end

         if (grant) tag_wr <= tag_wr + PW'(1);
         if (rv)    tag_rd <= tag_rd + PW'(1);

         if (redirect_i) begin
            rd_ptr <= wr_ptr;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   // Storage arrays carry no reset; validity is tracked by the counters.
   always_ff @(posedge clk_i) begin
      if (grant) tag_mem[tag_wr] <= fetch_pc;
      if (push) begin
         fifo_data[wr_ptr] <= icache_rdata_i;
         fifo_pc[wr_ptr]   <= tag_mem[tag_rd];
      end
   end

   always_comb begin
      instr_valid_o = (count != '0);
      instr_data_o  = instr_valid_o ? fifo_data[rd_ptr] : '0;
      instr_pc_o    = instr_valid_o ? fifo_pc[rd_ptr]   : '0;
   end

endmodule

// File: tb/tb_triumph_if_stage.sv
module tb_triumph_if_stage;

   localparam logic [31:0] KEY = 32'h5A5A_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        ivalid;
   logic [31:0] idata;
   logic [31:0] ipc;

   logic        gnt_en;
   int          lat;
   int          mcyc = 0;
   int          tests = 0;
   int          fails = 0;
   int          n_grant = 0;
   int          n_cons = 0;

   typedef struct {
      logic [31:0] a;
      int          due;
   } rsp_t;

   rsp_t        q[$];
   logic [31:0] glog[$];
   logic [31:0] got_pc[$];
   logic [31:0] got_data[$];
   logic [31:0] exp_pc;

   always #5 clk = ~clk;

   assign gnt = req & gnt_en;

   triumph_if_stage #(.BOOT_ADDR(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .clk_i(clk), .rstn_i(rst), .stall_i(stall), .redirect_i(redirect),
      .redirect_pc_i(redirect_pc), .icache_req_o(req), .icache_addr_o(addr),
      .icache_gnt_i(gnt), .icache_rvalid_i(rvalid), .icache_rdata_i(rdata),
      .instr_valid_o(ivalid), .instr_data_o(idata), .instr_pc_o(ipc)
   );

   // Instruction cache model: in-order responses 'lat' cycles after grant.
   always @(posedge clk) begin
      if (!rst && req && gnt) begin
         q.push_back('{addr, mcyc + lat});
         glog.push_back(addr);
         n_grant++;
      end
      if (rst) q.delete();
      mcyc++;
      #2;
      if (q.size() > 0 && q[0].due <= mcyc) begin
         rvalid = 1'b1;
         rdata  = q[0].a ^ KEY;
         q.delete(0);
      end else begin
         rvalid = 1'b0;
         rdata  = '0;
      end
   end

   // Consumer monitor
   always @(posedge clk) begin
      if (!rst && ivalid && !stall) begin
         got_pc.push_back(ipc);
         got_data.push_back(idata);
         n_cons++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200000");
      $fatal(1);
   end

   task automatic cyc(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      gnt_en = 1'b1; lat = 1;
      cyc(3);
      tests++; if (req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b required 0", req); end
      tests++; if (addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h required 00000000", addr); end
      tests++; if (ivalid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b required 0", ivalid); end
      tests++; if (idata !== 32'h0) begin fails++; $display("FAIL reset_data: got %h required 00000000", idata); end
      tests++; if (ipc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h required 00000000", ipc); end
   endtask

   task automatic test_startup_stream;
      rst = 1'b0;
      glog.delete(); got_pc.delete(); got_data.delete();
      n_grant = 0; n_cons = 0;
      // cycle 0: BOOT, no request
      tests++; if (req !== 1'b0) begin fails++; $display("FAIL boot_req: got %b required 0", req); end
      cyc(1);
      tests++; if (req !== 1'b1 || addr !== 32'h0) begin fails++; $display("FAIL first_req: got req=%b addr=%h required req=1 addr=00000000", req, addr); end
      cyc(1);
      tests++; if (ivalid !== 1'b0) begin fails++; $display("FAIL valid_c2: got %b required 0", ivalid); end
      cyc(1);
      tests++; if (ivalid !== 1'b1 || ipc !== 32'h0 || idata !== KEY) begin fails++; $display("FAIL first_instr: got v=%b pc=%h d=%h required v=1 pc=00000000 d=%h", ivalid, ipc, idata, KEY); end
      cyc(16);
      tests++; if (got_pc.size() < 8) begin fails++; $display("FAIL stream_count: got %0d required >=8", got_pc.size()); end
      for (int unsigned i = 0; i < glog.size(); i++) begin
         tests++; if (glog[i] !== 32'(4 * i)) begin fails++; $display("FAIL stream_addr[%0d]: got %h required %h", i, glog[i], 32'(4 * i)); end
      end
      exp_pc = 32'h0;
      for (int unsigned i = 0; i < got_pc.size(); i++) begin
         tests++; if (got_pc[i] !== exp_pc || got_data[i] !== (exp_pc ^ KEY)) begin fails++; $display("FAIL stream_instr[%0d]: got pc=%h d=%h required pc=%h d=%h", i, got_pc[i], got_data[i], exp_pc, exp_pc ^ KEY); end
         exp_pc += 32'd4;
      end
      got_pc.delete(); got_data.delete();
   endtask

   task automatic test_stall;
      stall = 1'b1;
      cyc(6);
      tests++; if (req !== 1'b0) begin fails++; $display("FAIL stall_req: got %b required 0", req); end
      tests++; if (ivalid !== 1'b1) begin fails++; $display("FAIL stall_valid: got %b required 1", ivalid); end
      tests++; if (n_grant - n_cons !== 2) begin fails++; $display("FAIL stall_buffered: got %0d required 2", n_grant - n_cons); end
      stall = 1'b0;
      cyc(10);
      tests++; if (got_pc.size() < 2) begin fails++; $display("FAIL stall_release_count: got %0d required >=2", got_pc.size()); end
      for (int unsigned i = 0; i < got_pc.size(); i++) begin
         tests++; if (got_pc[i] !== exp_pc || got_data[i] !== (exp_pc ^ KEY)) begin fails++; $display("FAIL stall_instr[%0d]: got pc=%h d=%h required pc=%h d=%h", i, got_pc[i], got_data[i], exp_pc, exp_pc ^ KEY); end
         exp_pc += 32'd4;
      end
   endtask

   task automatic test_redirect_outstanding;
      bit found = 0;
      lat = 3;
      for (int unsigned i = 0; i < 30 && !found; i++) begin
         cyc(1);
         if (q.size() == 2) found = 1;
      end
      tests++; if (!found) begin fails++; $display("FAIL redir_setup: got no 2-outstanding point required one within 30 cycles"); end
      redirect = 1'b1; redirect_pc = 32'h0000_0103;
      cyc(1);
      redirect = 1'b0;
      glog.delete(); got_pc.delete(); got_data.delete();
      tests++; if (ivalid !== 1'b0) begin fails++; $display("FAIL redir_flush: got %b required 0", ivalid); end
      cyc(20);
      tests++; if (glog.size() < 1 || glog[0] !== 32'h0000_0100) begin fails++; $display("FAIL redir_addr: got %h required 00000100", glog.size() ? glog[0] : 32'hX); end
      tests++; if (got_pc.size() < 2) begin fails++; $display("FAIL redir_count: got %0d required >=2", got_pc.size()); end
      exp_pc = 32'h0000_0100;
      for (int unsigned i = 0; i < got_pc.size(); i++) begin
         tests++; if (got_pc[i] !== exp_pc || got_data[i] !== (exp_pc ^ KEY)) begin fails++; $display("FAIL redir_instr[%0d]: got pc=%h d=%h required pc=%h d=%h", i, got_pc[i], got_data[i], exp_pc, exp_pc ^ KEY); end
         exp_pc += 32'd4;
      end
   endtask

   task automatic test_redirect_no_gnt;
      logic [31:0] held;
      bit          found = 0;
      lat = 1;
      gnt_en = 1'b0;
      for (int unsigned i = 0; i < 20 && !found; i++) begin
         cyc(1);
         if (req === 1'b1) found = 1;
      end
      tests++; if (!found) begin fails++; $display("FAIL nognt_setup: got req=%b required 1 within 20 cycles", req); end
      held = addr;
      for (int unsigned i = 0; i < 5; i++) begin
         cyc(1);
         tests++; if (req !== 1'b1 || addr !== held) begin fails++; $display("FAIL nognt_hold[%0d]: got req=%b addr=%h required req=1 addr=%h", i, req, addr, held); end
      end
      redirect = 1'b1; redirect_pc = 32'h0000_0200;
      cyc(1);
      redirect = 1'b0;
      glog.delete(); got_pc.delete(); got_data.delete();
      tests++; if (req !== 1'b1 || addr !== held) begin fails++; $display("FAIL nognt_after_redir: got req=%b addr=%h required req=1 addr=%h", req, addr, held); end
      cyc(1);
      gnt_en = 1'b1;
      cyc(1);
      tests++; if (addr !== 32'h0000_0200) begin fails++; $display("FAIL nognt_target: got %h required 00000200", addr); end
      cyc(15);
      tests++; if (glog.size() < 2 || glog[0] !== held || glog[1] !== 32'h0000_0200) begin fails++; $display("FAIL nognt_grants: got %0d grants first=%h required %h then 00000200", glog.size(), glog.size() ? glog[0] : 32'hX, held); end
      tests++; if (got_pc.size() < 2) begin fails++; $display("FAIL nognt_count: got %0d required >=2", got_pc.size()); end
      exp_pc = 32'h0000_0200;
      for (int unsigned i = 0; i < got_pc.size(); i++) begin
         tests++; if (got_pc[i] !== exp_pc || got_data[i] !== (exp_pc ^ KEY)) begin fails++; $display("FAIL nognt_instr[%0d]: got pc=%h d=%h required pc=%h d=%h", i, got_pc[i], got_data[i], exp_pc, exp_pc ^ KEY); end
         exp_pc += 32'd4;
      end
   endtask

   task automatic test_redirect_rvalid_stall;
      bit found = 0;
      lat = 2;
      stall = 1'b1;
      for (int unsigned i = 0; i < 20 && !found; i++) begin
         cyc(1);
         if (q.size() > 0 && q[0].due == mcyc) found = 1;
      end
      tests++; if (!found) begin fails++; $display("FAIL rvstall_setup: got no rvalid cycle required one within 20 cycles"); end
      redirect = 1'b1; redirect_pc = 32'h0000_0300;
      cyc(1);
      redirect = 1'b0;
      glog.delete(); got_pc.delete(); got_data.delete();
      tests++; if (ivalid !== 1'b0) begin fails++; $display("FAIL rvstall_flush: got %b required 0", ivalid); end
      cyc(6);
      tests++; if (ivalid !== 1'b1 || ipc !== 32'h0000_0300) begin fails++; $display("FAIL rvstall_head: got v=%b pc=%h required v=1 pc=00000300", ivalid, ipc); end
      stall = 1'b0;
      cyc(10);
      tests++; if (got_pc.size() < 2) begin fails++; $display("FAIL rvstall_count: got %0d required >=2", got_pc.size()); end
      exp_pc = 32'h0000_0300;
      for (int unsigned i = 0; i < got_pc.size(); i++) begin
         tests++; if (got_pc[i] !== exp_pc || got_data[i] !== (exp_pc ^ KEY)) begin fails++; $display("FAIL rvstall_instr[%0d]: got pc=%h d=%h required pc=%h d=%h", i, got_pc[i], got_data[i], exp_pc, exp_pc ^ KEY); end
         exp_pc += 32'd4;
      end
   endtask

   task automatic test_pc_wrap;
      logic [31:0] exp_a [3];
      exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0000_0000;
      lat = 1;
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      cyc(1);
      redirect = 1'b0;
      glog.delete(); got_pc.delete(); got_data.delete();
      cyc(12);
      tests++; if (glog.size() < 3) begin fails++; $display("FAIL wrap_count: got %0d grants required >=3", glog.size()); end
      for (int unsigned i = 0; i < 3 && i < glog.size(); i++) begin
         tests++; if (glog[i] !== exp_a[i]) begin fails++; $display("FAIL wrap_addr[%0d]: got %h required %h", i, glog[i], exp_a[i]); end
      end
      exp_pc = 32'hFFFF_FFF8;
      for (int unsigned i = 0; i < got_pc.size(); i++) begin
         tests++; if (got_pc[i] !== exp_pc || got_data[i] !== (exp_pc ^ KEY)) begin fails++; $display("FAIL wrap_instr[%0d]: got pc=%h d=%h required pc=%h d=%h", i, got_pc[i], got_data[i], exp_pc, exp_pc ^ KEY); end
         exp_pc += 32'd4;
      end
   endtask

   initial begin
      test_reset();
      test_startup_stream();
      test_stall();
      test_redirect_outstanding();
      test_redirect_no_gnt();
      test_redirect_rvalid_stall();
      test_pc_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
